// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
//   Bundles the producer request side and the two common-data-bus lanes of
//   cdb_arbiter.
//
//   req_valid  [4]          per-producer result present (0=ALU0,1=ALU1,2=LD0,3=LD1)
//   req_tag    [4*TAG_W]    producer i tag in [i*TAG_W +: TAG_W]; tag 0 = none
//   req_value  [4*DATA_W]   producer i value in [i*DATA_W +: DATA_W]
//   req_ready  [4]          producer i holding FIFO can accept
//   cdb_tag0/1, cdb_value0/1  registered broadcast lanes; tag 0 = idle
//
//   master: producers + lane consumers.  slave: the arbiter.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
);
    logic [3:0]          req_valid;
    logic [4*TAG_W-1:0]  req_tag;
    logic [4*DATA_W-1:0] req_value;
    logic [3:0]          req_ready;
    logic [TAG_W-1:0]    cdb_tag0;
    logic [DATA_W-1:0]   cdb_value0;
    logic [TAG_W-1:0]    cdb_tag1;
    logic [DATA_W-1:0]   cdb_value1;

    modport master (
        output req_valid, req_tag, req_value,
        input  req_ready, cdb_tag0, cdb_value0, cdb_tag1, cdb_value1
    );

    modport slave (
        input  req_valid, req_tag, req_value,
        output req_ready, cdb_tag0, cdb_value0, cdb_tag1, cdb_value1
    );
endinterface

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares two result broadcast lanes among four producers (ALU0, ALU1, LD0,
//   LD1). Each producer owns a DEPTH-entry holding FIFO; every cycle a 2-bit
//   round-robin scan grants up to two non-empty FIFO heads onto the lanes,
//   which are registered and read 0 (tag and value) when idle.
//
//   clk    rising-edge clock
//   rst    asynchronous, active-low reset
//   flush  synchronous squash of all queued results and of both lanes
//   bus    cdb_arbiter_if.slave: producer requests/ready and lane outputs
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);
    localparam int NREQ  = 4;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } entry_t;

    entry_t           mem_q    [NREQ][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NREQ];
    logic [PTR_W-1:0] wr_ptr_d [NREQ];
    logic [PTR_W-1:0] rd_ptr_q [NREQ];
    logic [PTR_W-1:0] rd_ptr_d [NREQ];
    logic [CNT_W-1:0] count_q  [NREQ];
    logic [CNT_W-1:0] count_d  [NREQ];

    logic [NREQ-1:0]  ready;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  pop;

    logic [1:0]       rr_q, rr_d;
    logic             g0_v, g1_v;
    logic [1:0]       g0_idx, g1_idx;
    logic [1:0]       scan;

    entry_t           lane0_q, lane0_d;
    entry_t           lane1_q, lane1_d;

    // Per-FIFO status. Ready looks only at the registered count, so a full
    // FIFO stays not-ready in the cycle it pops. Flush blocks every push.
    // NOTE: every signal driven in always_comb gets a value before any
    // conditional logic; a path that leaves one unassigned infers a latch.
    always_comb begin
        ready = '0;
        elig  = '0;
        push  = '0;
        for (int i = 0; i < NREQ; i++) begin
            ready[i] = (count_q[i] < CNT_W'(DEPTH));
            elig[i]  = (count_q[i] != '0);
            push[i]  = bus.req_valid[i] && ready[i] && !flush
                       && (bus.req_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

    assign bus.req_ready = ready;

    // Round-robin scan starting at rr_q: first eligible takes lane 0, second
    // takes lane 1. Each index appears once in the scan, so one requester can
    // never hold both lanes.
    always_comb begin
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        scan   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = rr_q + 2'(k);
            if (elig[scan]) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_idx = scan;
                end else if (!g1_v) begin
                    g1_v   = 1'b1;
                    g1_idx = scan;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NREQ; i++) begin
            pop[i] = !flush && ((g0_v && (g0_idx == 2'(i))) ||
                                (g1_v && (g1_idx == 2'(i))));
        end
    end

    // Next state for pointers, counts, rr and the lane registers.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
        end

        rr_d = rr_q;
        if (g1_v) begin
            rr_d = g1_idx + 2'd1;
        end else if (g0_v) begin
            rr_d = g0_idx + 2'd1;
        end

        lane0_d = g0_v ? mem_q[g0_idx][rd_ptr_q[g0_idx]] : '0;
        lane1_d = g1_v ? mem_q[g1_idx][rd_ptr_q[g1_idx]] : '0;

        if (flush) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            rr_d    = '0;
            lane0_d = '0;
            lane1_d = '0;
        end
    end

    // NOTE: FIFO storage has no reset; an entry is only ever read when the
    // count says it was written, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= '{tag:   bus.req_tag[i*TAG_W +: TAG_W],
                                          value: bus.req_value[i*DATA_W +: DATA_W]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_q    <= '0;
            lane0_q <= '0;
            lane1_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            rr_q    <= rr_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
        end
    end

    assign bus.cdb_tag0   = lane0_q.tag;
    assign bus.cdb_value0 = lane0_q.value;
    assign bus.cdb_tag1   = lane1_q.tag;
    assign bus.cdb_value1 = lane1_q.value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter (TAG_W=5, DATA_W=32, DEPTH=2). Inputs change
//   1 time unit after each rising edge; outputs are sampled at that same point,
//   i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    int checks = 0;
    int errors = 0;

    cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Value that accompanies a tag in this bench; idle lanes carry 0.
    function automatic logic [31:0] vof(input int t);
        return (t == 0) ? 32'h0 : 32'hCAFE_0000 + 32'(t * 17);
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic lanes(input string name, input int t0, input logic [31:0] v0,
                         input int t1, input logic [31:0] v1);
        check({name, "_tag0"},   64'(bus.cdb_tag0),   64'(t0));
        check({name, "_value0"}, 64'(bus.cdb_value0), 64'(v0));
        check({name, "_tag1"},   64'(bus.cdb_tag1),   64'(t1));
        check({name, "_value1"}, 64'(bus.cdb_value1), 64'(v1));
    endtask

    task automatic lanes_t(input string name, input int t0, input int t1);
        lanes(name, t0, vof(t0), t1, vof(t1));
    endtask

    task automatic push_set(input int i, input int t);
        bus.req_valid[i]              = 1'b1;
        bus.req_tag[i*TAG_W +: TAG_W] = 5'(t);
        bus.req_value[i*32 +: 32]     = vof(t);
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_value = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        idle();
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'hF);
        lanes_t("rst", 0, 0);
        tick();
        tick();
        rst = 1'b1;

        // Mid-stream reset: two results on the lanes, one still queued in LD0.
        push_set(0, 7);
        push_set(1, 8);
        push_set(2, 12);
        tick();
        idle();
        lanes_t("pre_grant", 0, 0);
        tick();
        lanes_t("busy", 7, 8);
        #2;
        rst = 1'b0;
        #1;
        lanes_t("async_rst", 0, 0);
        check("async_rst_ready", 64'(bus.req_ready), 64'hF);
        tick();
        lanes_t("in_rst", 0, 0);
        rst = 1'b1;
        tick();
        lanes_t("no_stale_a", 0, 0);
        tick();
        lanes_t("no_stale_b", 0, 0);

        // Single push: ALU0 tag 5 value 0x3FC, visible two cycles later on lane 0.
        push_set(0, 5);
        bus.req_value[31:0] = 32'h3FC;
        tick();
        idle();
        lanes_t("t1_wait", 0, 0);
        tick();
        lanes("t1_out", 5, 32'h3FC, 0, 32'h0);
        tick();
        lanes_t("t1_after", 0, 0);

        // Flush while idle returns rr to 0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        lanes_t("flush_idle", 0, 0);

        // All four at once with rr = 0.
        for (int i = 0; i < 4; i++) push_set(i, i + 1);
        tick();
        idle();
        check("t2_ready", 64'(bus.req_ready), 64'hF);
        tick();
        lanes_t("t2_c2", 1, 2);
        tick();
        lanes_t("t2_c3", 3, 4);
        tick();
        lanes_t("t2_c4", 0, 0);
        // rr back at 0: ALU0 must beat LD1 for lane 0.
        push_set(0, 10);
        push_set(3, 11);
        tick();
        idle();
        tick();
        lanes_t("t2_rr0", 10, 11);

        // Sustained load: ALU0 and LD1 broadcast every cycle.
        for (int k = 0; k < 6; k++) begin
            push_set(0, 16 + k);
            push_set(3, 24 + k);
            tick();
            check("t3_ready", 64'(bus.req_ready), 64'hF);
            if (k == 0) lanes_t("t3_first", 0, 0);
            else        lanes_t("t3_stream", 16 + k - 1, 24 + k - 1);
        end
        idle();
        tick();
        lanes_t("t3_last", 21, 29);
        tick();
        lanes_t("t3_drain", 0, 0);

        // Backpressure on ALU1 (rr = 0, all empty).
        push_set(2, 6);
        tick();
        idle();
        push_set(1, 13);
        push_set(0, 7);
        push_set(3, 8);
        tick();
        lanes_t("t4_e1", 6, 0);
        idle();
        push_set(1, 14);
        push_set(0, 9);
        push_set(3, 10);
        tick();
        lanes_t("t4_e2", 8, 7);
        check("t4_full_ready", 64'(bus.req_ready), 64'b1101);
        idle();
        push_set(1, 15);
        tick();
        lanes_t("t4_e3", 13, 10);
        check("t4_ready_back", 64'(bus.req_ready), 64'hF);
        idle();
        tick();
        lanes_t("t4_e4", 9, 14);
        tick();
        lanes_t("t4_e5", 0, 0);
        tick();
        lanes_t("t4_lost", 0, 0);

        // Tag-0 push is dropped.
        push_set(0, 0);
        bus.req_value[31:0] = 32'hDEAD_BEEF;
        tick();
        idle();
        check("t5_ready", 64'(bus.req_ready), 64'hF);
        tick();
        lanes_t("t5_a", 0, 0);
        tick();
        lanes_t("t5_b", 0, 0);

        // Flush with pending work (rr = 2 here).
        for (int i = 0; i < 4; i++) push_set(i, 20 + i);
        tick();
        lanes_t("t6_f1", 0, 0);
        for (int i = 0; i < 4; i++) push_set(i, 24 + i);
        tick();
        lanes_t("t6_f2", 22, 23);
        check("t6_f2_ready", 64'(bus.req_ready), 64'b1100);
        idle();
        flush = 1'b1;
        push_set(2, 9);
        tick();
        flush = 1'b0;
        idle();
        lanes_t("t6_flush", 0, 0);
        check("t6_ready", 64'(bus.req_ready), 64'hF);
        for (int k = 0; k < 3; k++) begin
            tick();
            lanes_t("t6_quiet", 0, 0);
        end
        push_set(1, 17);
        tick();
        idle();
        tick();
        lanes_t("t6_resume", 17, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the two result broadcast lanes (lane 0 and lane 1, tag plus value) among four producers: ALU0, ALU1, LD0 and LD1. Each producer pushes completed results into its own small holding FIFO. Each cycle a round-robin scheduler grants up to two FIFO heads onto the lanes. Reservation stations, including the jump-register station, and the register-status logic consume the registered lane outputs, with tag 0 meaning "no broadcast".

## Interface

Parameters:

- TAG_W, 5, tag width; tag 0 is reserved as "none".
- DATA_W, 32, result value width.
- DEPTH, 2, entries per requester FIFO (power of two, ≥2).

Ports:

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous squash of all pending results.
- req_valid  in  4  per requester: result present this cycle. Bit 0 = ALU0, bit 1 = ALU1, bit 2 = LD0, bit 3 = LD1.
- req_tag  in  4*TAG_W  requester i tag in bits [i*TAG_W +: TAG_W].
- req_value  in  4*DATA_W  requester i value in bits [i*DATA_W +: DATA_W].
- req_ready  out  4  per requester: FIFO can accept. Combinational from the registered count: count < DEPTH.
- cdb_tag0  out  TAG_W  lane 0 tag, registered; 0 when idle.
- cdb_value0  out  DATA_W  lane 0 value, registered; 0 when idle.
- cdb_tag1  out  TAG_W  lane 1 tag, registered; 0 when idle.
- cdb_value1  out  DATA_W  lane 1 value, registered; 0 when idle.

## Operation

- **Push:** FIFO i is written when req_valid[i] && req_ready[i] && req_tag[i] != 0.
  - A push with tag 0 is dropped silently.
  - A push while not ready is lost. Producers must hold until ready.
- **FIFO:** circular, with wr/rd pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
- **Eligibility:** requester i is eligible when count_i != 0.
- **Scheduling** uses a 2-bit round-robin pointer rr:
  - Scan i = rr, rr+1, rr+2, rr+3 (mod 4).
  - The first eligible requester gets lane 0; the second eligible gets lane 1.
  - Granted FIFOs pop this edge; their heads are loaded into the lane registers.
  - Lanes with no grant load tag 0 and value 0.
- **rr update:** rr becomes (last granted index + 1) mod 4. With no grant, rr is unchanged.
- At most one entry per FIFO is popped per cycle. The same requester never occupies both lanes.
- **flush** (has priority over push and grant in the same cycle):
  - All counts and pointers go to 0 and rr goes to 0.
  - Both lanes load tag 0 and value 0 at that edge.
  - Pushes in the flush cycle are discarded.
- **Reset** (async assert, at any time including mid-operation):
  - FIFOs empty, rr = 0.
  - cdb_tag0/1 = 0, cdb_value0/1 = 0.
  - req_ready = 4'b1111.
  - FIFO data storage need not be cleared.

## Timing

- A result pushed at edge E appears on a lane no earlier than the cycle after edge E+1, i.e. two cycles after being presented.
- Lane outputs are held exactly one cycle per grant. Consumers sample them on the next edge.
- Throughput: 2 results/cycle aggregate, 1 result/cycle per requester.
- req_ready does not see same-cycle pops. A full FIFO reports not-ready for the cycle in which it pops.
- Starvation bound: an eligible head is granted within 2 cycles.

## Test plan

1. **Reset and single push.** Assert rst low mid-stream, then release. Push ALU0 tag 5, value 0x3FC.
   - During reset: all outputs 0 and req_ready = 1111.
   - Two cycles after the push: cdb_tag0 = 5, cdb_value0 = 0x3FC, cdb_tag1 = 0.
   - Next cycle: both lanes 0.
2. **All four push at once.** Push tags 1, 2, 3, 4 with rr = 0.
   - Cycle +2: lanes carry (1, 2).
   - Cycle +3: lanes carry (3, 4).
   - rr ends at 0.
3. **Fairness under sustained load.** LD1 and ALU0 push continuously with distinct tags.
   - Each broadcasts every cycle.
   - No requester's head waits more than 2 cycles.
4. **Backpressure.** With DEPTH = 2, push ALU1 on three consecutive cycles while lanes are kept busy by higher-priority rr positions.
   - req_ready[1] drops after two entries.
   - The third push is not stored.
   - All stored tags are broadcast in push order.
5. **Tag-0 push.** Push ALU0 with tag 0.
   - Nothing is stored and nothing is broadcast.
   - req_ready is unchanged.
6. **Flush with pending work.** Fill all FIFOs, then assert flush together with a new push of tag 9.
   - Next cycle: lanes are 0 and req_ready = 1111.
   - Tag 9 never appears on either lane.
